// File: rtl/ram_burst_writer.sv
// rtl/ram_burst_writer.sv - show-ahead FIFO feeding fixed-length write bursts to the DDR2 local port
// Optional dropped-word counter: define RAM_BURST_WRITER_OVF_CNT_EN.
module ram_burst_writer #(
  parameter int          BURST_LEN  = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter logic [24:0] ADDR_LIMIT = 25'h1000000
) (
  input  logic        phy_clk,
  input  logic        reset_phy_clk_n,
  input  logic        enable,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        local_init_done,
  input  logic        local_ready,
  output logic        local_write_req,
  output logic        local_burstbegin,
  output logic [24:0] local_address,
  output logic [2:0]  local_size,
  output logic [3:0]  local_be,
  output logic [31:0] local_wdata,
  output logic        local_read_req,
  output logic        busy,
  output logic [15:0] burst_count,
  output logic [15:0] ovf_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [24:0]   addr_q, addr_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [25:0]   addr_sum;
  logic          push, pop;

  // Ready is gated by reset so the source sees backpressure while held in reset.
  assign din_ready = reset_phy_clk_n && (count_q < CW'(FIFO_DEPTH));
  assign push      = din_valid && din_ready;
  assign pop       = local_write_req && local_ready;

  always_ff @(posedge phy_clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge phy_clk) begin
    if (!reset_phy_clk_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Widened by one bit so the wrap compare near ADDR_LIMIT cannot overflow.
  assign addr_sum = {1'b0, addr_q} + 26'(BURST_LEN);

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    addr_d           = addr_q;
    burst_cnt_d      = burst_cnt_q;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && local_init_done && (count_q >= CW'(BURST_LEN))) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        local_write_req  = 1'b1;
        local_burstbegin = (beat_q == 3'd0);
        if (local_ready) begin
          if (beat_q == 3'(BURST_LEN - 1)) begin
            state_d     = IDLE;
            beat_d      = '0;
            addr_d      = (addr_sum >= {1'b0, ADDR_LIMIT}) ? BASE_ADDR : addr_sum[24:0];
            burst_cnt_d = burst_cnt_q + 16'd1;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (!reset_phy_clk_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      addr_q      <= BASE_ADDR;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef RAM_BURST_WRITER_OVF_CNT_EN
  logic [15:0] ovf_q;
  always_ff @(posedge phy_clk) begin
    if (!reset_phy_clk_n) begin
      ovf_q <= '0;
    end else if (din_valid && !din_ready && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end
  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

  // Head word is masked outside a burst so the data bus reads zero after reset.
  assign local_wdata    = (state_q == BURST) ? mem[rd_ptr_q] : '0;
  assign local_address  = addr_q;
  assign local_size     = 3'(BURST_LEN);
  assign local_be       = 4'hF;
  assign local_read_req = 1'b0;
  assign busy           = (state_q == BURST);
  assign burst_count    = burst_cnt_q;

endmodule

// File: doc/ram_burst_writer.md
# ram_burst_writer

Write-side stream master feeding the DDR2 controller's local (Avalon-style) port. Accepts a 32-bit word stream from the Medipix pattern generator, buffers it in an internal show-ahead FIFO, and issues fixed-length write bursts to sequential, wrapping word addresses once the memory reports `local_init_done`. Sits directly upstream of `ram_controller_phy` and runs in its `phy_clk` domain.

## Interface
Parameters:
- `BURST_LEN`, 4: beats per burst, 1..7; driven on `local_size`.
- `FIFO_DEPTH`, 16: FIFO words; power of 2 and ≥ 2·BURST_LEN.
- `BASE_ADDR`, 25'h0: first burst address, in words.
- `ADDR_LIMIT`, 25'h1000000: exclusive upper bound; address wraps to BASE_ADDR.

Ports:
- `phy_clk`  in  1  controller clock; all logic is on its rising edge.
- `reset_phy_clk_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  permits new bursts to start.
- `din`  in  32  stream data.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  FIFO can accept a word.
- `local_init_done`  in  1  memory calibrated.
- `local_ready`  in  1  controller accepts the current beat.
- `local_write_req`  out  1  write beat valid.
- `local_burstbegin`  out  1  first beat of a burst.
- `local_address`  out  25  burst start address.
- `local_size`  out  3  constant BURST_LEN.
- `local_be`  out  4  constant 4'hF.
- `local_wdata`  out  32  FIFO head word.
- `local_read_req`  out  1  constant 0.
- `busy`  out  1  state is BURST.
- `burst_count`  out  16  completed bursts, wrapping.
- `ovf_count`  out  16  dropped-word counter; see Configuration.

## Operation
- FIFO: a push occurs when `din_valid && din_ready`; a pop occurs when `local_write_req && local_ready`. `din_ready = (count < FIFO_DEPTH)`, using the registered count. A pop in the same cycle does not raise `din_ready`. A simultaneous push and pop leaves `count` unchanged.
- FSM:
  - IDLE → BURST when `enable && local_init_done && count ≥ BURST_LEN`.
  - BURST: `local_write_req=1` and `local_wdata` = FIFO head. `beat` starts at 0 and increments on each accepted beat. `local_burstbegin = (beat==0)`.
  - BURST → IDLE on the accepted beat where `beat==BURST_LEN-1`. On that edge: `addr ← (addr+BURST_LEN ≥ ADDR_LIMIT) ? BASE_ADDR : addr+BURST_LEN`, and `burst_count` increments modulo 2^16.
- `local_address` holds `addr` for the whole burst.
- Deasserting `enable` mid-burst does not abort; the burst completes and no new burst starts.
- Dropping `local_init_done` mid-burst is ignored; the controller's own handshake governs.
- The address sum is computed at 26 bits so the wrap compare cannot overflow.

## Timing
- Reset values: state IDLE, FIFO empty, `din_ready=0` during reset and 1 afterwards, `local_write_req=0`, `local_burstbegin=0`, `local_address=BASE_ADDR`, `local_wdata=0`, `busy=0`, `burst_count=0`, `ovf_count=0`.
- A word pushed at edge N is counted at N+1. The earliest `local_write_req` is at N+2 after the BURST_LEN-th push.
- `local_wdata`, `local_burstbegin` and `local_address` are stable while `local_ready=0`.
- Each burst is followed by at least one IDLE cycle (one dead cycle between back-to-back bursts).
- Reset asserted mid-burst: all outputs return to reset values on the next edge and buffered data is discarded.

## Configuration
- `RAM_BURST_WRITER_OVF_CNT_EN` defined: `ovf_count` increments, saturating at 16'hFFFF, on every cycle with `din_valid && !din_ready`.
- Not defined: `ovf_count` is tied to 0 and no counter logic is built.
- Backpressure via `din_ready` is identical in both builds.

## Test plan
- Reset, `local_init_done=1`, `enable=1`, `local_ready=1`, push 4 words 0xA0..0xA3: one burst at address 0 with data A0..A3 in order. `burstbegin` is high on A0 only. `burst_count=1`, and the next burst uses address 4.
- Same stimulus with `local_ready` toggling 1,0,1,0: each beat is held stable while not ready; 4 pops and 4 accepted beats in total.
- `ADDR_LIMIT=8`, stream 12 words continuously: burst addresses are 0, 4, 0.
- `local_init_done=0`, push 20 words: `din_ready` falls after 16 words and no request is issued. With the macro defined and `din_valid` held, `ovf_count` advances by 1 per cycle. Without the macro it stays 0.
- Drop `enable` after the first accepted beat: the burst finishes all 4 beats, then the block stays IDLE with 8 words remaining buffered.
- Pull reset low at beat 2: `local_write_req=0`, FIFO empty and `local_address=BASE_ADDR` on the next edge.
